// File: rtl/rr_arbiter_wrr_scheduler.sv
// Weighted round-robin scheduler: registered one-hot grant, per-requester runtime quanta.
// Optional per-requester starvation monitor enabled by defining RR_ARB_STARVE_MON_EN.
module rr_arbiter_wrr_scheduler #(
  parameter int unsigned N           = 4,
  parameter int unsigned QW          = 4,
  parameter int unsigned DEF_QUANTUM = 3
`ifdef RR_ARB_STARVE_MON_EN
  ,parameter int unsigned STARVE_LIM = 12
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic                  cfg_we,
  input  logic [$clog2(N)-1:0]  cfg_idx,
  input  logic [QW-1:0]         cfg_quantum,
  output logic [N-1:0]          gnt,
  output logic                  gnt_valid,
  output logic [$clog2(N)-1:0]  gnt_id,
  output logic                  slice_last
`ifdef RR_ARB_STARVE_MON_EN
  ,output logic [N-1:0]         starve
`endif
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [QW-1:0]   cnt, cnt_nxt;
  logic [QW-1:0]   qcur, qcur_nxt;
  logic [QW-1:0]   q     [N];
  logic [QW-1:0]   q_nxt [N];
  logic [N-1:0]    gnt_nxt;
  logic [IW-1:0]   gnt_id_nxt;
  logic            gnt_valid_nxt;
  logic            issue;
  logic [IW-1:0]   sel;
  logic            last;

  // First requester at or after start, wrapping modulo N.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] start);
    logic [IW-1:0] found;
    logic          hit;
    int unsigned   idx;
    found = start;
    hit   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(start) + k) % N;
      if (!hit && r[IW'(idx)]) begin
        hit   = 1'b1;
        found = IW'(idx);
      end
    end
    return found;
  endfunction

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    return (32'(i) == N - 1) ? '0 : IW'(i + 1'b1);
  endfunction

  // A programmed quantum of zero still yields a one-cycle slice.
  function automatic logic [QW-1:0] q_eff(input logic [QW-1:0] v);
    return (v == '0) ? QW'(1) : v;
  endfunction

  assign last       = (cnt == qcur - 1'b1);
  assign slice_last = gnt_valid && last;

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    qcur_nxt   = qcur;
    gnt_nxt    = gnt;
    gnt_id_nxt = gnt_id;
    q_nxt      = q;
    issue      = 1'b0;
    sel        = '0;

    for (int unsigned i = 0; i < N; i++) begin
      if (cfg_we && cfg_idx == IW'(i)) q_nxt[i] = cfg_quantum;
    end

    case (state)
      IDLE: begin
        if (|req) begin
          issue = 1'b1;
          sel   = pick(req, ptr);
        end
      end
      GRANT: begin
        // Searching from g+1 lands back on g only when nobody else is waiting.
        if (!req[gnt_id] || last) begin
          if (|req) begin
            issue = 1'b1;
            sel   = pick(req, inc_idx(gnt_id));
          end else begin
            state_nxt  = IDLE;
            gnt_nxt    = '0;
            gnt_id_nxt = '0;
            cnt_nxt    = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Old q value is latched here; a same-cycle write lands only in q_nxt.
    if (issue) begin
      state_nxt    = GRANT;
      gnt_nxt      = '0;
      gnt_nxt[sel] = 1'b1;
      gnt_id_nxt   = sel;
      cnt_nxt      = '0;
      qcur_nxt     = q_eff(q[sel]);
      ptr_nxt      = inc_idx(sel);
    end

    gnt_valid_nxt = |gnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      qcur      <= QW'(DEF_QUANTUM);
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      for (int unsigned i = 0; i < N; i++) q[i] <= QW'(DEF_QUANTUM);
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      qcur      <= qcur_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      q         <= q_nxt;
    end
  end

`ifdef RR_ARB_STARVE_MON_EN
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0] wait_cnt [N];
  logic [SW-1:0] wait_nxt [N];
  logic [N-1:0]  starve_nxt;

  // Saturating per-requester wait counters; observation only.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      wait_nxt[i] = '0;
      if (req[i] && !gnt[i]) begin
        wait_nxt[i] = (wait_cnt[i] == SW'(STARVE_LIM)) ? wait_cnt[i] : wait_cnt[i] + 1'b1;
      end
      starve_nxt[i] = (wait_nxt[i] == SW'(STARVE_LIM));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve <= '0;
      for (int unsigned i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      starve   <= starve_nxt;
      wait_cnt <= wait_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter_wrr_scheduler.sv
// Self-checking bench for rr_arbiter_wrr_scheduler: vector table plus scoreboard queue.
module tb_rr_arbiter_wrr_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned QW = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [QW-1:0] cfg_quantum;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;
  logic          slice_last;

  rr_arbiter_wrr_scheduler #(.N(N), .QW(QW), .DEF_QUANTUM(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_quantum(cfg_quantum), .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .slice_last(slice_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic [N-1:0]  req;
    logic          we;
    logic [IW-1:0] idx;
    logic [QW-1:0] qv;
    logic [N-1:0]  gnt;
    logic          sl;
  } vec_t;

  typedef struct {
    logic [N-1:0] gnt;
    logic         sl;
    int           line;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void v(logic r, logic [N-1:0] rq, logic [N-1:0] g, logic s);
    vec_t e;
    e.rst_n = r; e.req = rq; e.we = 1'b0; e.idx = '0; e.qv = '0; e.gnt = g; e.sl = s;
    tbl.push_back(e);
  endfunction

  function automatic void w(logic [IW-1:0] i, logic [QW-1:0] q, logic [N-1:0] rq, logic [N-1:0] g, logic s);
    vec_t e;
    e.rst_n = 1'b1; e.req = rq; e.we = 1'b1; e.idx = i; e.qv = q; e.gnt = g; e.sl = s;
    tbl.push_back(e);
  endfunction

  function automatic logic [IW-1:0] id_of(logic [N-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N); i++) if (g[i]) r = IW'(i);
    return r;
  endfunction

  task automatic check(string name, int line, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, line, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
  task automatic step(vec_t e, int line);
    exp_t x;
    rst_n = e.rst_n; req = e.req; cfg_we = e.we; cfg_idx = e.idx; cfg_quantum = e.qv;
    x.gnt = e.gnt; x.sl = e.sl; x.line = line;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", line);
    end else begin
      x = sb.pop_front();
      check("gnt",        x.line, 32'(gnt),        32'(x.gnt));
      check("gnt_valid",  x.line, 32'(gnt_valid),  32'(|x.gnt));
      check("gnt_id",     x.line, 32'(gnt_id),     32'(id_of(x.gnt)));
      check("slice_last", x.line, 32'(slice_last), 32'(x.sl));
      check("onehot0",    x.line, 32'($onehot0(gnt)), 32'(1));
    end
  endtask

  initial begin
    int pulses;
    int gaps;
    rst_n = 1'b0; req = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_quantum = '0;

    // Reset dominance, then a lone requester re-granted every 3 cycles.
    v(0, 4'b0000, 4'b0000, 0);
    v(0, 4'b1111, 4'b0000, 0);
    v(1, 4'b0001, 4'b0001, 0);
    v(1, 4'b0001, 4'b0001, 0);
    v(1, 4'b0001, 4'b0001, 1);
    v(1, 4'b0001, 4'b0001, 0);
    v(1, 4'b0001, 4'b0001, 0);
    v(1, 4'b0001, 4'b0001, 1);
    v(1, 4'b0001, 4'b0001, 0);
    v(1, 4'b0000, 4'b0000, 0);
    // Full rotation with default quanta.
    v(0, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 4; k++) begin
      logic [N-1:0] g;
      g = 4'b0001 << k;
      v(1, 4'b1111, g, 0);
      v(1, 4'b1111, g, 0);
      v(1, 4'b1111, g, 1);
    end
    v(1, 4'b1111, 4'b0001, 0);
    v(1, 4'b0000, 4'b0000, 0);
    // Unequal quanta; mid-slice write and same-edge write/grant latch the old value.
    w(2'd1, 4'd1, 4'b0000, 4'b0000, 0);
    w(2'd2, 4'd5, 4'b0000, 4'b0000, 0);
    v(1, 4'b0110, 4'b0010, 1);
    v(1, 4'b0110, 4'b0100, 0);
    w(2'd2, 4'd2, 4'b0110, 4'b0100, 0);
    v(1, 4'b0110, 4'b0100, 0);
    v(1, 4'b0110, 4'b0100, 0);
    v(1, 4'b0110, 4'b0100, 1);
    w(2'd1, 4'd3, 4'b0110, 4'b0010, 1);
    v(1, 4'b0110, 4'b0100, 0);
    v(1, 4'b0110, 4'b0100, 1);
    v(1, 4'b0110, 4'b0010, 0);
    v(1, 4'b0110, 4'b0010, 0);
    v(1, 4'b0110, 4'b0010, 1);
    v(1, 4'b0110, 4'b0100, 0);
    v(1, 4'b0000, 4'b0000, 0);
    // Early drop with wrap past index 3, then a zero quantum acting as one cycle.
    v(0, 4'b0000, 4'b0000, 0);
    v(1, 4'b0100, 4'b0100, 0);
    v(1, 4'b0101, 4'b0100, 0);
    v(1, 4'b0001, 4'b0001, 0);
    v(1, 4'b0000, 4'b0000, 0);
    w(2'd0, 4'd0, 4'b0000, 4'b0000, 0);
    v(1, 4'b0001, 4'b0001, 1);
    v(1, 4'b0001, 4'b0001, 1);
    v(1, 4'b0000, 4'b0000, 0);
    // Reset mid-slice restores quanta and pointer.
    w(2'd2, 4'd7, 4'b0000, 4'b0000, 0);
    v(1, 4'b0100, 4'b0100, 0);
    v(1, 4'b0100, 4'b0100, 0);
    v(0, 4'b1111, 4'b0000, 0);
    for (int k = 0; k < 3; k++) begin
      logic [N-1:0] g;
      g = 4'b0001 << k;
      v(1, 4'b1111, g, 0);
      v(1, 4'b1111, g, 0);
      v(1, 4'b1111, g, 1);
    end
    v(1, 4'b1111, 4'b1000, 0);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Lone requester held: grant must never drop and slice_last pulses every third cycle.
    rst_n = 1'b0; req = '0; cfg_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; req = 4'b0001;
    pulses = 0; gaps = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0001) gaps++;
      if (slice_last === 1'b1) pulses++;
    end
    check("no_gap_cycles", 0, 32'(gaps), 32'(0));
    check("slice_last_count", 0, 32'(pulses), 32'(4));
    check("scoreboard_drained", 0, 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
